// File: rtl/pb_io_hub.sv
// KCPSM6 port-bus hub: a bank of write registers, registered input read mux, and an
// N-source maskable interrupt controller with pending/W1C status and an ack handshake.
module pb_io_hub #(
  parameter int         N_IN       = 8,
  parameter int         N_OUT      = 16,
  parameter logic [7:0] IN_BASE    = 8'h00,
  parameter logic [7:0] OUT_BASE   = 8'h40,
  parameter logic [7:0] IRQ_BASE   = 8'hF0,
  parameter int         N_IRQ      = 2,
  parameter logic [7:0] IRQ_TOGGLE = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  input  logic                 k_write_strobe,
  input  logic                 read_strobe,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic                 interrupt_ack,
  input  logic [8*N_IN-1:0]    in_data,
  output logic [8*N_OUT-1:0]   out_data,
  output logic [N_OUT-1:0]     out_wr,
  input  logic [N_IRQ-1:0]     irq_src
);

  localparam int IN_END  = int'(IN_BASE) + N_IN;
  localparam int OUT_END = int'(OUT_BASE) + N_OUT;
  localparam int IRQ_END = int'(IRQ_BASE) + 2;

  function automatic bit overlaps(input int a, input int n, input int b, input int m);
    return (a < b + m) && (b < a + n);
  endfunction

  if (N_IN < 1 || N_IN > 64 || N_OUT < 1 || N_OUT > 64 || N_IRQ < 1 || N_IRQ > 8) begin : g_bad_size
    $error("pb_io_hub: port or source count out of range");
  end
  if (IN_END > 256 || OUT_END > 256 || IRQ_END > 256) begin : g_bad_end
    $error("pb_io_hub: address range exceeds 8'hFF");
  end
  if (overlaps(int'(IN_BASE), N_IN, int'(OUT_BASE), N_OUT) ||
      overlaps(int'(IN_BASE), N_IN, int'(IRQ_BASE), 2) ||
      overlaps(int'(OUT_BASE), N_OUT, int'(IRQ_BASE), 2)) begin : g_bad_overlap
    $error("pb_io_hub: address ranges overlap");
  end

  localparam logic [8:0]       IN_LO  = 9'(IN_BASE);
  localparam logic [8:0]       OUT_LO = 9'(OUT_BASE);
  localparam logic [8:0]       IRQ_LO = 9'(IRQ_BASE);
  localparam logic [N_IRQ-1:0] TMODE  = IRQ_TOGGLE[N_IRQ-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t             state;
  logic [N_IRQ-1:0]   pending, mask, src_q, evt, w1c;
  logic               prime, req, mask_we, stat_hit, mask_hit, in_hit, out_hit;
  logic [8:0]         pid9, in_off, out_off;
  logic [N_OUT-1:0]   wr_sel;
  logic [7:0]         rd_data;
  logic               unused;

  assign unused = read_strobe;

  // Offsets wrap to large values below the base, so a single upper compare suffices.
  assign pid9     = {1'b0, port_id};
  assign in_off   = pid9 - IN_LO;
  assign out_off  = pid9 - OUT_LO;
  assign in_hit   = in_off < 9'(N_IN);
  assign out_hit  = out_off < 9'(N_OUT);
  assign stat_hit = pid9 == IRQ_LO;
  assign mask_hit = pid9 == IRQ_LO + 9'd1;

  always_comb begin
    wr_sel = '0;
    if (write_strobe) begin
      for (int i = 0; i < N_OUT; i++)
        if (out_hit && out_off[5:0] == 6'(i)) wr_sel[i] = 1'b1;
    end else if (k_write_strobe) begin
      for (int i = 0; i < N_OUT; i++)
        if ({2'b00, port_id[3:0]} == 6'(i)) wr_sel[i] = 1'b1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_IN; i++)
      if (in_hit && in_off[5:0] == 6'(i)) rd_data = in_data[8*i +: 8];
    for (int i = 0; i < N_OUT; i++)
      if (out_hit && out_off[5:0] == 6'(i)) rd_data = out_data[8*i +: 8];
    if (stat_hit) rd_data = 8'(pending);
    if (mask_hit) rd_data = 8'(mask);
  end

  assign w1c     = (write_strobe && stat_hit) ? out_port[N_IRQ-1:0] : '0;
  assign mask_we = write_strobe && mask_hit;
  assign evt     = prime ? (((irq_src ^ src_q) & TMODE) | (irq_src & ~src_q & ~TMODE)) : '0;
  assign req     = |(pending & mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_wr   <= '0;
      in_port  <= 8'h00;
    end else begin
      out_wr  <= wr_sel;
      in_port <= rd_data;
      for (int i = 0; i < N_OUT; i++)
        if (wr_sel[i]) out_data[8*i +: 8] <= out_port;
    end
  end

  // A new event outranks a W1C clear landing on the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
      src_q   <= '0;
      prime   <= 1'b0;
    end else begin
      src_q   <= irq_src;
      prime   <= 1'b1;
      pending <= (pending & ~w1c) | evt;
      if (mask_we) mask <= out_port[N_IRQ-1:0];
    end
  end

  // SERVICE holds until every masked pending bit is cleared, so firmware must drain all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      interrupt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          state     <= S_ASSERT;
          interrupt <= 1'b1;
        end
        S_ASSERT: if (interrupt_ack) begin
          state     <= S_SERVICE;
          interrupt <= 1'b0;
        end
        S_SERVICE: if (!req) state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
